// File: rtl/recv_data.sv
// ----------------------------------------------------------------------------
// recv_data
// Receive side of the ranging datapath. A one-cycle send_pulse arms a
// time-of-flight measurement. The asynchronous echo input is synchronised and
// deglitched, and the block reports the cycle count from arm to the first
// echo rising edge that stays high for MIN_WIDTH cycles. If no such edge
// arrives inside the TIMEOUT window, a timeout strobe is reported instead.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   send_pulse : one-cycle arm strobe (transmit trigger)
//   echo_in    : asynchronous echo comparator output
//   busy       : high while a measurement is armed
//   tof_valid  : one-cycle strobe, new result on tof_value
//   tof_value  : latched time-of-flight count (held until next tof_valid)
//   timeout    : one-cycle strobe, window expired without a qualified echo
// ----------------------------------------------------------------------------
module recv_data #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MIN_WIDTH   = 3,
    parameter int unsigned TIMEOUT     = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             send_pulse,
    input  logic             echo_in,
    output logic             busy,
    output logic             tof_valid,
    output logic [CNT_W-1:0] tof_value,
    output logic             timeout
);

    localparam int unsigned      WID_W    = $clog2(MIN_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);
    localparam logic [WID_W-1:0] WID_DONE = WID_W'(MIN_WIDTH);
    localparam logic [WID_W-1:0] WID_ONE  = WID_W'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_echo_d;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_edge_cnt;
    logic [WID_W-1:0]       r_width;
    logic                   r_busy;
    logic                   r_tof_valid;
    logic [CNT_W-1:0]       r_tof_value;
    logic                   r_timeout;

    logic                   w_echo_s;
    logic                   w_rise;
    logic [WID_W-1:0]       w_width_nxt;
    logic                   w_qual;
    logic [CNT_W-1:0]       w_edge_val;
    logic                   w_last;

    // Echo synchroniser chain plus one history flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync   <= '0;
            r_echo_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], echo_in};
            r_echo_d <= w_echo_s;
        end
    end

    assign w_echo_s    = r_sync[SYNC_STAGES-1];
    assign w_rise      = w_echo_s & ~r_echo_d;
    assign w_width_nxt = r_width + WID_ONE;
    assign w_last      = (r_cnt == LAST_CNT);

    // Qualification completes in the cycle the width counter reaches
    // MIN_WIDTH; with MIN_WIDTH == 1 that is the edge cycle itself, so the
    // captured count must bypass r_edge_cnt in that case.
    assign w_qual = (r_state == S_WAIT) && w_echo_s &&
                    (w_rise ? (WID_DONE == WID_ONE)
                            : ((r_width != '0) && (w_width_nxt == WID_DONE)));
    assign w_edge_val = w_rise ? r_cnt : r_edge_cnt;

    // Measurement FSM with registered strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_edge_cnt  <= '0;
            r_width     <= '0;
            r_busy      <= 1'b0;
            r_tof_valid <= 1'b0;
            r_tof_value <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_tof_valid <= 1'b0;
            r_timeout   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_width <= '0;
                    if (send_pulse) begin
                        r_state <= S_WAIT;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    // cnt never passes TIMEOUT-1: the window closes there
                    r_cnt <= r_cnt + CNT_W'(1);
                    // Width tracking: a drop before MIN_WIDTH discards the candidate
                    if (!w_echo_s) begin
                        r_width <= '0;
                    end else if (w_rise) begin
                        r_width    <= WID_ONE;
                        r_edge_cnt <= r_cnt;
                    end else if (r_width != '0) begin
                        r_width <= w_width_nxt;
                    end
                    // Qualification wins over a coincident window expiry
                    if (w_qual) begin
                        r_tof_valid <= 1'b1;
                        r_tof_value <= w_edge_val;
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                    end else if (w_last) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign tof_valid = r_tof_valid;
    assign tof_value = r_tof_value;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_recv_data.sv
// ----------------------------------------------------------------------------
// tb_recv_data
// Directed bench for recv_data (TIMEOUT=200, MIN_WIDTH=3, SYNC_STAGES=2).
// Inputs are driven and outputs sampled on the falling clock edge. The loop
// index c equals the DUT's cnt value in the cycle being sampled; to make the
// synced echo rise at cnt=E, echo_in is raised at c = E - SYNC_STAGES.
// ----------------------------------------------------------------------------
module tb_recv_data;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned SYNC    = 2;
    localparam int unsigned MIN_W   = 3;
    localparam int unsigned TMO     = 200;
    localparam int          NVEC    = 10;
    localparam int          NONE    = -100;

    logic             clk = 1'b0;
    logic             rst;
    logic             send_pulse;
    logic             echo_in;
    logic             busy;
    logic             tof_valid;
    logic [CNT_W-1:0] tof_value;
    logic             timeout;

    int n_cmp = 0;
    int n_bad = 0;

    // Echo as up to two synced-high intervals [s, e) in cnt units;
    // s < 0 means echo already high at arm time. kind: 1 = tof_valid, 2 = timeout.
    typedef struct {
        int               s1, e1, s2, e2;
        int               rearm;
        int               kind;
        int               cyc;
        logic [CNT_W-1:0] val;
    } vec_t;

    vec_t vecs [NVEC];

    recv_data #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC),
        .MIN_WIDTH   (MIN_W),
        .TIMEOUT     (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .send_pulse (send_pulse),
        .echo_in    (echo_in),
        .busy       (busy),
        .tof_valid  (tof_valid),
        .tof_value  (tof_value),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit in_iv(input int c, input int s, input int e);
        return (c >= s - int'(SYNC)) && (c < e - int'(SYNC));
    endfunction

    // One armed measurement driven from a table record
    task automatic run_vec(input int idx, input vec_t v);
        int               n_str    = 0;
        int               kind     = 0;
        int               at       = -1;
        logic [CNT_W-1:0] val      = '0;
        logic             busy_pre = 1'b0;
        bit               both     = 1'b0;
        echo_in = (v.s1 < 0);
        repeat (6) @(negedge clk);
        send_pulse = 1'b1;
        @(negedge clk);
        send_pulse = 1'b0;
        for (int c = 0; c <= 225; c++) begin
            if (tof_valid && timeout) both = 1'b1;
            if (tof_valid || timeout) begin
                n_str++;
                if (n_str == 1) begin
                    kind = tof_valid ? 1 : 2;
                    at   = c;
                    val  = tof_value;
                end
            end
            if (c == v.cyc - 1) busy_pre = busy;
            echo_in    = in_iv(c, v.s1, v.e1) || in_iv(c, v.s2, v.e2);
            send_pulse = (c == v.rearm);
            @(negedge clk);
        end
        echo_in    = 1'b0;
        send_pulse = 1'b0;
        repeat (5) @(negedge clk);
        chk($sformatf("v%0d strobe kind", idx),  32'(kind),     32'(v.kind));
        chk($sformatf("v%0d strobe cycle", idx), 32'(at),       32'(v.cyc));
        chk($sformatf("v%0d strobe count", idx), 32'(n_str),    32'd1);
        chk($sformatf("v%0d both strobes", idx), 32'(both),     32'd0);
        chk($sformatf("v%0d busy before", idx),  32'(busy_pre), 32'd1);
        chk($sformatf("v%0d value at strobe", idx), 32'(val),   32'(v.val));
        chk($sformatf("v%0d value held", idx),   32'(tof_value), 32'(v.val));
        chk($sformatf("v%0d busy after", idx),   32'(busy),     32'd0);
    endtask

    initial begin
        int               n_str;
        int               n_busy;
        int               at;
        logic [CNT_W-1:0] val;

        //        s1    e1    s2    e2   rearm kind cyc  val
        vecs[0] = '{100,  110,  NONE, NONE, -1, 1, 103, 16'd100}; // basic
        vecs[1] = '{40,   42,   60,   65,   -1, 1, 63,  16'd60};  // 2-cycle glitch then real
        vecs[2] = '{NONE, NONE, NONE, NONE, -1, 2, 200, 16'd60};  // timeout, value held
        vecs[3] = '{197,  217,  NONE, NONE, -1, 1, 200, 16'd197}; // qualifies on last cycle
        vecs[4] = '{198,  218,  NONE, NONE, -1, 2, 200, 16'd197}; // one cycle too late
        vecs[5] = '{5,    6,    7,    10,   -1, 1, 10,  16'd7};   // 1-cycle glitch
        vecs[6] = '{2,    5,    NONE, NONE, -1, 1, 5,   16'd2};   // exactly MIN_WIDTH
        vecs[7] = '{50,   52,   NONE, NONE, -1, 2, 200, 16'd2};   // MIN_WIDTH-1 only
        vecs[8] = '{196,  199,  NONE, NONE, -1, 1, 199, 16'd196}; // just inside window
        vecs[9] = '{-10,  20,   30,   45,   10, 1, 33,  16'd30};  // high at arm + re-arm

        rst        = 1'b1;
        send_pulse = 1'b0;
        echo_in    = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy",      32'(busy),      32'd0);
        chk("reset tof_valid", 32'(tof_valid), 32'd0);
        chk("reset timeout",   32'(timeout),   32'd0);
        chk("reset tof_value", 32'(tof_value), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

        // Async reset in the middle of a measurement
        send_pulse = 1'b1;
        @(negedge clk);
        send_pulse = 1'b0;
        repeat (50) @(negedge clk);
        chk("pre-reset busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async busy",      32'(busy),      32'd0);
        chk("async tof_valid", 32'(tof_valid), 32'd0);
        chk("async timeout",   32'(timeout),   32'd0);
        chk("async tof_value", 32'(tof_value), 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        n_str  = 0;
        n_busy = 0;
        for (int c = 0; c < 60; c++) begin
            if (tof_valid || timeout) n_str++;
            if (busy) n_busy++;
            echo_in = (c >= 20) && (c < 30);
            @(negedge clk);
        end
        echo_in = 1'b0;
        chk("post-reset strobes", 32'(n_str),  32'd0);
        chk("post-reset busy",    32'(n_busy), 32'd0);
        repeat (5) @(negedge clk);

        // Back-to-back: re-arm in the same cycle as tof_valid
        send_pulse = 1'b1;
        @(negedge clk);
        send_pulse = 1'b0;
        at = -1;
        val = '0;
        for (int c = 0; c <= 20; c++) begin
            if (tof_valid) begin
                at  = c;
                val = tof_value;
                send_pulse = 1'b1;
                break;
            end
            echo_in = in_iv(c, 5, 8);
            @(negedge clk);
        end
        echo_in = 1'b0;
        chk("b2b first cycle", 32'(at),  32'd8);
        chk("b2b first value", 32'(val), 32'd5);
        @(negedge clk);
        send_pulse = 1'b0;
        chk("b2b re-armed busy", 32'(busy), 32'd1);
        at = -1;
        val = '0;
        for (int c = 0; c <= 20; c++) begin
            if (tof_valid && at < 0) begin
                at  = c;
                val = tof_value;
            end
            echo_in = in_iv(c, 4, 10);
            @(negedge clk);
        end
        echo_in = 1'b0;
        chk("b2b second cycle", 32'(at),  32'd7);
        chk("b2b second value", 32'(val), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got stuck, expected completion");
        $fatal(1);
    end

endmodule
